// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing for the RAM-backed synchronous FIFO controller.
// Holds the grant encoding and the depth helper used by the top module.
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WRITE = 2'd1,
    GNT_READ  = 2'd2
  } grant_t;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/sync_fifo_arb.sv
// Round-robin arbiter that picks one RAM access per cycle: push write or head read.
// Purely combinational; the caller keeps last_grant.
module sync_fifo_arb
  import sync_fifo_pkg::*;
(
  input  logic   rd_elig,
  input  logic   wr_elig,
  input  logic   wr_valid,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   wr_ready
);

  logic wr_req;

  // wr_ready must not look at wr_valid, so the tie-break only uses eligibility.
  assign wr_ready = wr_elig & ~(rd_elig & (last_grant == GNT_WRITE));
  assign wr_req   = wr_valid & wr_elig;

  always_comb begin
    grant = GNT_NONE;
    if (rd_elig && wr_req) begin
      grant = (last_grant == GNT_WRITE) ? GNT_READ : GNT_WRITE;
    end else if (rd_elig) begin
      grant = GNT_READ;
    end else if (wr_req) begin
      grant = GNT_WRITE;
    end
  end

endmodule

// File: rtl/sync_fifo_mem_ctrl.sv
// FIFO controller driving a single-port RAM with one-cycle registered reads.
// Pointers, occupancy, one-entry head register and the RAM port mux live here.
module sync_fifo_mem_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(fifo_depth(ADDR_W));

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_pend;
  logic              out_valid;
  grant_t            last_grant;
  grant_t            grant;

  logic pop;
  logic rd_elig;
  logic wr_elig;

  assign pop     = out_valid & rd_ready;
  // A read may only be issued if its data will have somewhere to land two cycles later.
  assign rd_elig = (ram_cnt != '0) & ~rd_pend & (~out_valid | pop);
  assign wr_elig = (ram_cnt != DEPTH_CNT);

  sync_fifo_arb u_arb (
    .rd_elig    (rd_elig),
    .wr_elig    (wr_elig),
    .wr_valid   (wr_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .wr_ready   (wr_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      ram_cnt    <= '0;
      rd_pend    <= 1'b0;
      out_valid  <= 1'b0;
      rd_data    <= '0;
      last_grant <= GNT_WRITE;
    end else begin
      unique case (grant)
        GNT_WRITE: begin
          wp         <= wp + ADDR_W'(1);
          ram_cnt    <= ram_cnt + (ADDR_W+1)'(1);
          last_grant <= GNT_WRITE;
        end
        GNT_READ: begin
          rp         <= rp + ADDR_W'(1);
          ram_cnt    <= ram_cnt - (ADDR_W+1)'(1);
          last_grant <= GNT_READ;
        end
        default: ;
      endcase

      rd_pend <= (grant == GNT_READ);

      if (rd_pend) begin
        rd_data   <= mem_data_out;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign mem_write_enable = (grant == GNT_WRITE);
  assign mem_address      = (grant == GNT_WRITE) ? wp : rp;
  assign mem_data_in      = wr_data;

  assign rd_valid = out_valid;
  assign count    = ram_cnt + (ADDR_W+1)'(rd_pend) + (ADDR_W+1)'(out_valid);
  assign full     = (ram_cnt == DEPTH_CNT);
  assign empty    = (count == '0);

  // The head register and the read pipe stage are exclusive by construction.
  a_pend_valid_onehot: assert property (@(posedge clk) disable iff (rst)
    !(rd_pend && out_valid))
    else $error("rd_pend and out_valid both set");

endmodule
